cross_bar_2x2: RTL and testbench
================================

# cross_bar_2x2

Two-master / two-slave bus crossbar between the CPU request ports (`master_cpu` instances) and the RAM ports (`slave_ram` instances). Each upstream request is routed to one downstream port by address MSB. Each downstream port has its own arbiter, so two transfers to different slaves run concurrently. Requests to the same slave are serialised by arbitration, and every response is routed back to the master that owns the grant.

## Interface
- `ADDR_W`, default 32: address width; bit `ADDR_W-1` selects the slave.
- `DATA_W`, default 32: data width.
- `clk` input 1: single clock, rising edge.
- `resetn` input 1: asynchronous, active-high reset. Asserted value 1 resets the block; the name is kept for codebase consistency.
- `s1_req`, `s2_req` input 1: upstream request, from the CPUs.
- `s1_cmd`, `s2_cmd` input 1: 1 = write, 0 = read.
- `s1_addr`, `s2_addr` input `ADDR_W`: request address.
- `s1_wdata`, `s2_wdata` input `DATA_W`: write data.
- `s1_ack`, `s2_ack` output 1: transfer complete, one-cycle pulse.
- `s1_rdata`, `s2_rdata` output `DATA_W`: read data, valid while the matching ack is high.
- `m1_req`, `m2_req` output 1: downstream request, to the RAMs.
- `m1_cmd`/`m2_cmd`, `m1_addr`/`m2_addr`, `m1_wdata`/`m2_wdata` outputs: forwarded from the granted upstream port.
- `m1_ack`, `m2_ack` input 1: downstream completion.
- `m1_rdata`, `m2_rdata` input `DATA_W`: downstream read data.

## Operation
- **Decode:** `sN_addr[ADDR_W-1]` selects the target. 0 → `m1`, 1 → `m2`. The address is forwarded unmodified.
- **Upstream protocol:** the master holds req, cmd, addr and wdata stable until it sees ack. The slave pulses ack for one cycle, with rdata valid in that cycle.
- **Arbiter states:** one arbiter per downstream port, each with states `IDLE`, `GNT_S1`, `GNT_S2`.
  - `IDLE`: if one upstream port requests this target, grant it. If both request it, grant per the priority pointer (see Configuration).
  - `GNT_Sx`: on `m_ack`, return to `IDLE`, and set the pointer to prefer the other source.
- **Forwarding in `GNT_Sx`:**
  - The downstream request equals `sx_req`; cmd, addr and wdata are muxed combinationally from `sx`.
  - `m_ack` and `m_rdata` are routed combinationally to `sx_ack` and `sx_rdata`.
- **Non-owner outputs:** a non-granted upstream port sees ack = 0 and rdata = 0.
- **Idle downstream outputs:** in `IDLE`, the downstream req, cmd, addr and wdata are all 0.
- **Both slaves at once:** `s1` → `m1` and `s2` → `m2` in the same cycle are granted independently and proceed in parallel.
- **Request dropped before ack:** this is a protocol violation. The downstream req follows the upstream req low, but the grant is held until `m_ack`.
- **Reset values:** all arbiters `IDLE`; pointers prefer `s1`; all ack, req and data outputs 0.
- **Reset mid-transfer:** the grant is released immediately (asynchronously) and the downstream req drops in the same cycle. The outstanding transfer is abandoned with no upstream ack.

## Timing
- Grant is registered: a request seen at edge N is granted after edge N, so the downstream req is visible in cycle N+1. This adds one cycle of latency.
- Response path is combinational: `m_ack` to `s_ack` adds zero cycles.
- After an ack, the arbiter is back in `IDLE` for at least one cycle. The next grant for the same target is registered at the following edge, giving a minimum of 2 cycles per transfer per target.
- A master may raise a new req in the cycle after its ack.

## Configuration
- `CROSS_BAR_RR_EN` defined: round-robin arbitration. On a tie in `IDLE`, the source preferred by the pointer wins. The pointer flips to the other source after each completed grant.
- `CROSS_BAR_RR_EN` undefined: fixed priority, `s1` always wins ties. The pointer logic is removed.

## Structure
- **Package `cross_bar_pkg`:** `ADDR_W`/`DATA_W` defaults, the arbiter state enum `arb_state_t` (`IDLE`, `GNT_S1`, `GNT_S2`), and the request struct `bus_req_t` (req, cmd, addr, wdata).
- **Sub-module `cross_bar_arbiter`:** one instance per downstream port. It takes the two decoded requests and `m_ack`, and outputs the grant state. The top-level block holds the decode and the muxes.

## Test plan
- **Basic write:** reset, then `s1` writes 0xDEADBEEF to addr 0x0000_0010. `m1_req` rises one cycle after `s1_req` with identical addr and data; `m1_ack` → `s1_ack` in the same cycle; `m2_req` stays 0.
- **Read routing:** `s2` reads addr 0x8000_0004, `m2_rdata` = 0x12345678 with ack. `s2_ack` = 1 and `s2_rdata` = 0x12345678 in the same cycle; `s1_ack` = 0.
- **Parallel, different targets:** `s1` → 0x0000_0000 and `s2` → 0x8000_0000 in the same cycle. Both downstream reqs rise in the same cycle; both complete independently.
- **Contention:** both masters request 0x0000_0008 simultaneously, three times.
  - `CROSS_BAR_RR_EN`: grant order `s1`, `s2`, `s1`.
  - Without the macro: `s1` is granted whenever both are requesting.
  - The loser's ack stays 0 until its own grant.
- **Reset mid-transfer:** assert `resetn` = 1 while `GNT_S1` is pending. `m1_req` = 0 immediately and `s1_ack` never pulses; after release, a new `s1` request completes normally.

Source files
------------

// File: rtl/cross_bar_pkg.sv
// Shared types for the 2x2 bus crossbar: default widths, arbiter states,
// request bundle and the downstream forwarding mux.
package cross_bar_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_S1 = 2'd1,
    GNT_S2 = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic                  req;
    logic                  cmd;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } bus_req_t;

  // Selects the granted upstream bundle; an idle port drives all zeros.
  function automatic bus_req_t fwd_req(input arb_state_t st,
                                       input bus_req_t   a,
                                       input bus_req_t   b);
    bus_req_t r;
    r = '0;
    case (st)
      GNT_S1:  r = a;
      GNT_S2:  r = b;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cross_bar_arbiter.sv
// Per-downstream-port arbiter. Round-robin tie-break when CROSS_BAR_RR_EN
// is defined, otherwise fixed priority with s1 winning ties.
//
// state  | meaning
// -------+-----------------------------------------------
// IDLE   | no owner, downstream outputs forced to zero
// GNT_S1 | s1 owns this port until m_ack
// GNT_S2 | s2 owns this port until m_ack
module cross_bar_arbiter
  import cross_bar_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       req1,
  input  logic       req2,
  input  logic       m_ack,
  output arb_state_t state
);

  logic prefer_s2;

`ifdef CROSS_BAR_RR_EN
  // After a completed grant, the next tie goes to the other source.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      prefer_s2 <= 1'b0;
    end else if (m_ack) begin
      if (state == GNT_S1)      prefer_s2 <= 1'b1;
      else if (state == GNT_S2) prefer_s2 <= 1'b0;
    end
  end
`else
  assign prefer_s2 = 1'b0;
`endif

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (req1 && (!req2 || !prefer_s2)) state <= GNT_S1;
          else if (req2)                     state <= GNT_S2;
        end
        // Grant is held until the slave acks, even if the master drops req.
        GNT_S1, GNT_S2: begin
          if (m_ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/cross_bar_2x2.sv
// Two-master / two-slave crossbar: address-MSB decode, one arbiter per RAM
// port, combinational response return. Optional macro: CROSS_BAR_RR_EN.
module cross_bar_2x2
  import cross_bar_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              s1_req,
  input  logic              s1_cmd,
  input  logic [ADDR_W-1:0] s1_addr,
  input  logic [DATA_W-1:0] s1_wdata,
  output logic              s1_ack,
  output logic [DATA_W-1:0] s1_rdata,
  input  logic              s2_req,
  input  logic              s2_cmd,
  input  logic [ADDR_W-1:0] s2_addr,
  input  logic [DATA_W-1:0] s2_wdata,
  output logic              s2_ack,
  output logic [DATA_W-1:0] s2_rdata,
  output logic              m1_req,
  output logic              m1_cmd,
  output logic [ADDR_W-1:0] m1_addr,
  output logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_ack,
  input  logic [DATA_W-1:0] m1_rdata,
  output logic              m2_req,
  output logic              m2_cmd,
  output logic [ADDR_W-1:0] m2_addr,
  output logic [DATA_W-1:0] m2_wdata,
  input  logic              m2_ack,
  input  logic [DATA_W-1:0] m2_rdata
);

  bus_req_t   s1_bus, s2_bus, m1_bus, m2_bus;
  arb_state_t arb_m1, arb_m2;
  logic       s1_to_m1, s1_to_m2, s2_to_m1, s2_to_m2;

  // Upstream bundles are widened into the package-sized struct.
  always_comb begin
    s1_bus                     = '0;
    s1_bus.req                 = s1_req;
    s1_bus.cmd                 = s1_cmd;
    s1_bus.addr[ADDR_W-1:0]    = s1_addr;
    s1_bus.wdata[DATA_W-1:0]   = s1_wdata;
    s2_bus                     = '0;
    s2_bus.req                 = s2_req;
    s2_bus.cmd                 = s2_cmd;
    s2_bus.addr[ADDR_W-1:0]    = s2_addr;
    s2_bus.wdata[DATA_W-1:0]   = s2_wdata;
  end

  assign s1_to_m1 = s1_req & ~s1_addr[ADDR_W-1];
  assign s1_to_m2 = s1_req &  s1_addr[ADDR_W-1];
  assign s2_to_m1 = s2_req & ~s2_addr[ADDR_W-1];
  assign s2_to_m2 = s2_req &  s2_addr[ADDR_W-1];

  cross_bar_arbiter u_arb_m1 (
    .clk    (clk),
    .resetn (resetn),
    .req1   (s1_to_m1),
    .req2   (s2_to_m1),
    .m_ack  (m1_ack),
    .state  (arb_m1)
  );

  cross_bar_arbiter u_arb_m2 (
    .clk    (clk),
    .resetn (resetn),
    .req1   (s1_to_m2),
    .req2   (s2_to_m2),
    .m_ack  (m2_ack),
    .state  (arb_m2)
  );

  assign m1_bus   = fwd_req(arb_m1, s1_bus, s2_bus);
  assign m2_bus   = fwd_req(arb_m2, s1_bus, s2_bus);

  assign m1_req   = m1_bus.req;
  assign m1_cmd   = m1_bus.cmd;
  assign m1_addr  = m1_bus.addr[ADDR_W-1:0];
  assign m1_wdata = m1_bus.wdata[DATA_W-1:0];
  assign m2_req   = m2_bus.req;
  assign m2_cmd   = m2_bus.cmd;
  assign m2_addr  = m2_bus.addr[ADDR_W-1:0];
  assign m2_wdata = m2_bus.wdata[DATA_W-1:0];

  // Responses return only to the current owner; everyone else sees zeros.
  assign s1_ack = ((arb_m1 == GNT_S1) & m1_ack) | ((arb_m2 == GNT_S1) & m2_ack);
  assign s2_ack = ((arb_m1 == GNT_S2) & m1_ack) | ((arb_m2 == GNT_S2) & m2_ack);

  always_comb begin
    s1_rdata = '0;
    s2_rdata = '0;
    if (arb_m1 == GNT_S1)      s1_rdata = m1_rdata;
    else if (arb_m2 == GNT_S1) s1_rdata = m2_rdata;
    if (arb_m1 == GNT_S2)      s2_rdata = m1_rdata;
    else if (arb_m2 == GNT_S2) s2_rdata = m2_rdata;
  end

endmodule

// File: tb/tb_cross_bar_2x2.sv
// Directed bench for cross_bar_2x2; expectations follow the macro
// CROSS_BAR_RR_EN in the same way as the design.
module tb_cross_bar_2x2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        s1_req, s1_cmd, s2_req, s2_cmd;
  logic [31:0] s1_addr, s1_wdata, s2_addr, s2_wdata;
  logic        s1_ack, s2_ack;
  logic [31:0] s1_rdata, s2_rdata;
  logic        m1_req, m1_cmd, m2_req, m2_cmd;
  logic [31:0] m1_addr, m1_wdata, m2_addr, m2_wdata;
  logic        m1_ack, m2_ack;
  logic [31:0] m1_rdata, m2_rdata;

  int n_vec = 0;
  int n_err = 0;

  cross_bar_2x2 #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .s1_req   (s1_req),
    .s1_cmd   (s1_cmd),
    .s1_addr  (s1_addr),
    .s1_wdata (s1_wdata),
    .s1_ack   (s1_ack),
    .s1_rdata (s1_rdata),
    .s2_req   (s2_req),
    .s2_cmd   (s2_cmd),
    .s2_addr  (s2_addr),
    .s2_wdata (s2_wdata),
    .s2_ack   (s2_ack),
    .s2_rdata (s2_rdata),
    .m1_req   (m1_req),
    .m1_cmd   (m1_cmd),
    .m1_addr  (m1_addr),
    .m1_wdata (m1_wdata),
    .m1_ack   (m1_ack),
    .m1_rdata (m1_rdata),
    .m2_req   (m2_req),
    .m2_cmd   (m2_cmd),
    .m2_addr  (m2_addr),
    .m2_wdata (m2_wdata),
    .m2_ack   (m2_ack),
    .m2_rdata (m2_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    s1_req = 0; s1_cmd = 0; s1_addr = 0; s1_wdata = 0;
    s2_req = 0; s2_cmd = 0; s2_addr = 0; s2_wdata = 0;
    m1_ack = 0; m1_rdata = 0; m2_ack = 0; m2_rdata = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  int exp_own [3];

  initial begin
`ifdef CROSS_BAR_RR_EN
    exp_own = '{1, 2, 1};
`else
    exp_own = '{1, 1, 1};
`endif
    resetn = 1'b1;
    clear_inputs();
    repeat (3) step();
    chk("rst_m1_req", m1_req, 0);
    chk("rst_m2_req", m2_req, 0);
    chk("rst_s1_ack", s1_ack, 0);
    chk("rst_m1_addr", m1_addr, 0);
    resetn = 1'b0;
    step();

    // basic write s1 -> m1
    s1_req = 1; s1_cmd = 1; s1_addr = 32'h0000_0010; s1_wdata = 32'hDEAD_BEEF;
    #2 chk("wr_pre_grant_req", m1_req, 0);
    step();
    #2;
    chk("wr_m1_req", m1_req, 1);
    chk("wr_m1_cmd", m1_cmd, 1);
    chk("wr_m1_addr", m1_addr, 32'h0000_0010);
    chk("wr_m1_wdata", m1_wdata, 32'hDEAD_BEEF);
    chk("wr_m2_req", m2_req, 0);
    chk("wr_s1_ack_early", s1_ack, 0);
    m1_ack = 1;
    #1;
    chk("wr_s1_ack", s1_ack, 1);
    chk("wr_s2_ack", s2_ack, 0);
    step();
    clear_inputs();
    #2;
    chk("wr_idle_req", m1_req, 0);
    chk("wr_idle_addr", m1_addr, 0);

    // read routing s2 -> m2
    s2_req = 1; s2_cmd = 0; s2_addr = 32'h8000_0004;
    step();
    #2;
    chk("rd_m2_req", m2_req, 1);
    chk("rd_m2_cmd", m2_cmd, 0);
    chk("rd_m2_addr", m2_addr, 32'h8000_0004);
    chk("rd_m1_req", m1_req, 0);
    m2_ack = 1; m2_rdata = 32'h1234_5678;
    #1;
    chk("rd_s2_ack", s2_ack, 1);
    chk("rd_s2_rdata", s2_rdata, 32'h1234_5678);
    chk("rd_s1_ack", s1_ack, 0);
    chk("rd_s1_rdata", s1_rdata, 0);
    step();
    clear_inputs();

    // parallel transfers to different slaves
    s1_req = 1; s1_cmd = 1; s1_addr = 32'h0000_0000; s1_wdata = 32'hA5A5_0001;
    s2_req = 1; s2_cmd = 0; s2_addr = 32'h8000_0000;
    step();
    #2;
    chk("par_m1_req", m1_req, 1);
    chk("par_m2_req", m2_req, 1);
    chk("par_m2_addr", m2_addr, 32'h8000_0000);
    m1_ack = 1;
    #1;
    chk("par_s1_ack", s1_ack, 1);
    chk("par_s2_ack_wait", s2_ack, 0);
    step();
    s1_req = 0; m1_ack = 0;
    m2_ack = 1; m2_rdata = 32'hCAFE_F00D;
    #1;
    chk("par_s2_ack", s2_ack, 1);
    chk("par_s2_rdata", s2_rdata, 32'hCAFE_F00D);
    chk("par_s1_ack_after", s1_ack, 0);
    step();
    clear_inputs();

    // contention on m1, both masters keep requesting
    s1_req = 1; s1_cmd = 1; s1_addr = 32'h0000_0008; s1_wdata = 32'h1111_1111;
    s2_req = 1; s2_cmd = 1; s2_addr = 32'h0000_0008; s2_wdata = 32'h2222_2222;
    for (int r = 0; r < 3; r++) begin
      step();
      #2;
      chk($sformatf("cont%0d_m1_req", r), m1_req, 1);
      chk($sformatf("cont%0d_owner", r), m1_wdata,
          (exp_own[r] == 1) ? 32'h1111_1111 : 32'h2222_2222);
      chk($sformatf("cont%0d_loser_pre", r), s1_ack | s2_ack, 0);
      m1_ack = 1;
      #1;
      chk($sformatf("cont%0d_s1_ack", r), s1_ack, (exp_own[r] == 1) ? 1 : 0);
      chk($sformatf("cont%0d_s2_ack", r), s2_ack, (exp_own[r] == 2) ? 1 : 0);
      step();
      m1_ack = 0;
      #2 chk($sformatf("cont%0d_idle", r), m1_req, 0);
    end
    s1_req = 0;
    step();
    #2 chk("cont_s2_final", m1_wdata, 32'h2222_2222);
    m1_ack = 1;
    #1 chk("cont_s2_final_ack", s2_ack, 1);
    step();
    clear_inputs();

    // request dropped before ack: grant held until m1_ack
    s1_req = 1; s1_cmd = 1; s1_addr = 32'h0000_0030; s1_wdata = 32'hAAAA_AAAA;
    step();
    #2 chk("drop_m1_req", m1_req, 1);
    s1_req = 0;
    s2_req = 1; s2_cmd = 1; s2_addr = 32'h0000_0040; s2_wdata = 32'hBBBB_BBBB;
    #1 chk("drop_follow", m1_req, 0);
    step();
    #2;
    chk("drop_held_req", m1_req, 0);
    chk("drop_held_s2_ack", s2_ack, 0);
    m1_ack = 1;
    #1;
    chk("drop_s1_ack", s1_ack, 1);
    chk("drop_s2_ack", s2_ack, 0);
    step();
    m1_ack = 0;
    #2 chk("drop_idle", m1_req, 0);
    step();
    #2;
    chk("drop_s2_grant", m1_req, 1);
    chk("drop_s2_wdata", m1_wdata, 32'hBBBB_BBBB);
    m1_ack = 1;
    #1 chk("drop_s2_done", s2_ack, 1);
    step();
    clear_inputs();

    // reset mid-transfer
    s1_req = 1; s1_cmd = 1; s1_addr = 32'h0000_0020; s1_wdata = 32'h0BAD_F00D;
    step();
    #2 chk("rmt_m1_req", m1_req, 1);
    resetn = 1;
    #1 chk("rmt_req_drop", m1_req, 0);
    m1_ack = 1;
    #1 chk("rmt_no_ack", s1_ack, 0);
    m1_ack = 0;
    step();
    chk("rmt_no_ack_hold", s1_ack, 0);
    step();
    resetn = 0;
    #2 chk("rmt_idle_after", m1_req, 0);
    step();
    #2;
    chk("rmt_regrant", m1_req, 1);
    chk("rmt_regrant_wdata", m1_wdata, 32'h0BAD_F00D);
    m1_ack = 1;
    #1 chk("rmt_s1_ack", s1_ack, 1);
    step();
    clear_inputs();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
